// File: rtl/loop_walk_pkg.sv
// loop_walk_pkg
// Shared types and width helpers for the loop_walk_seq sequencer.
//   loop_walk_state_e : IDLE / RUN / DONE walk states
//   outer_count()     : effective outer bound (NumOuter or $clog2(NumOuter))
//   outer_w/inner_w/value_w : port widths derived from the outer bound,
//                             each at least 1 so a zero-length walk still
//                             has legal vectors.
package loop_walk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } loop_walk_state_e;

  function automatic int outer_count(input int num_outer, input bit clog_mode);
    return clog_mode ? $clog2(num_outer) : num_outer;
  endfunction

  // k runs 0..OC-1
  function automatic int outer_w(input int oc);
    return (oc <= 1) ? 1 : $clog2(oc);
  endfunction

  // l runs 0..2**(OC-1)-1
  function automatic int inner_w(input int oc);
    return (oc <= 2) ? 1 : oc - 1;
  endfunction

  // value runs 1..2**OC-1
  function automatic int value_w(input int oc);
    return (oc <= 1) ? 1 : oc;
  endfunction

endpackage

// File: rtl/loop_walk_seq.sv
// loop_walk_seq
// Runtime walk of the nested iteration space k = 0..OC-1, l = 0..2**k-1,
// one valid/ready beat per (k, l) carrying value 2**k + l.
// Ports:
//   clk_i, rst_i         : clock, async active-high reset
//   start_i              : start request, honoured only in IDLE
//   ready_i              : downstream ready
//   valid_o              : beat valid (state RUN)
//   outer_idx_o          : k
//   inner_idx_o          : l
//   value_o              : (1 << k) | l
//   outer_last_o         : l == 2**k - 1
//   last_o               : final beat of the walk
//   busy_o               : state != IDLE
//   done_o               : one-cycle pulse after the walk
// Every output is decoded from the state and counter registers only.
module loop_walk_seq
  import loop_walk_pkg::*;
#(
  parameter int NumOuter = 3,
  parameter bit ClogMode = 1'b0,
  localparam int OC = outer_count(NumOuter, ClogMode),
  localparam int OW = outer_w(OC),
  localparam int IW = inner_w(OC),
  localparam int VW = value_w(OC)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [OW-1:0] outer_idx_o,
  output logic [IW-1:0] inner_idx_o,
  output logic [VW-1:0] value_o,
  output logic          outer_last_o,
  output logic          last_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int            OCM1   = (OC > 0) ? OC - 1 : 0;
  localparam logic [OW-1:0] K_LAST = OW'(OCM1);

  loop_walk_state_e r_state, w_next;
  logic [OW-1:0]    r_k;
  logic [IW-1:0]    r_l;

  logic [VW-1:0] w_pow, w_mask, w_l_ext;
  logic          w_outer_last, w_last, w_hs;

  // 2**k and its mask; l < 2**k always, so OR-ing l in equals adding it.
  assign w_pow        = VW'(1) << r_k;
  assign w_mask       = w_pow - VW'(1);
  assign w_l_ext      = VW'(r_l);
  assign w_outer_last = (w_l_ext == w_mask);
  assign w_last       = (r_k == K_LAST) && w_outer_last;
  assign w_hs         = (r_state == RUN) && ready_i;

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start_i) w_next = (OC > 0) ? RUN : DONE;
      RUN:  if (w_hs && w_last) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // k/l counters; cleared on the final handshake so a new walk starts at 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_k <= '0;
      r_l <= '0;
    end else if ((r_state == IDLE) && start_i) begin
      r_k <= '0;
      r_l <= '0;
    end else if (w_hs) begin
      if (!w_outer_last) begin
        r_l <= r_l + IW'(1);
      end else begin
        r_l <= '0;
        r_k <= w_last ? '0 : r_k + OW'(1);
      end
    end
  end

  // outputs: beat fields are forced to 0 outside RUN so idle/reset reads 0
  always_comb begin
    valid_o      = 1'b0;
    outer_idx_o  = '0;
    inner_idx_o  = '0;
    value_o      = '0;
    outer_last_o = 1'b0;
    last_o       = 1'b0;
    busy_o       = (r_state != IDLE);
    done_o       = (r_state == DONE);
    if (r_state == RUN) begin
      valid_o      = 1'b1;
      outer_idx_o  = r_k;
      inner_idx_o  = r_l;
      value_o      = w_pow | w_l_ext;
      outer_last_o = w_outer_last;
      last_o       = w_last;
    end
  end

endmodule

// File: tb/tb_loop_walk_seq.sv
module tb_loop_walk_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- DUT0: defaults, OC=3 ----------------
  logic       st0 = 1'b0, rdy0 = 1'b1;
  logic       v0, ol0, la0, bz0, dn0;
  logic [1:0] k0, l0;
  logic [2:0] val0;
  loop_walk_seq #(.NumOuter(3), .ClogMode(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(st0), .ready_i(rdy0), .valid_o(v0),
    .outer_idx_o(k0), .inner_idx_o(l0), .value_o(val0), .outer_last_o(ol0),
    .last_o(la0), .busy_o(bz0), .done_o(dn0));

  // ---------------- DUT1: ClogMode=1, NumOuter=1 -> OC=0 ----------------
  logic st1 = 1'b0, rdy1 = 1'b1;
  logic v1, ol1, la1, bz1, dn1;
  logic [0:0] k1, l1, val1;
  loop_walk_seq #(.NumOuter(1), .ClogMode(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(st1), .ready_i(rdy1), .valid_o(v1),
    .outer_idx_o(k1), .inner_idx_o(l1), .value_o(val1), .outer_last_o(ol1),
    .last_o(la1), .busy_o(bz1), .done_o(dn1));

  // ---------------- DUT2: ClogMode=1, NumOuter=8 -> OC=3 ----------------
  logic       st2 = 1'b0, rdy2 = 1'b1;
  logic       v2, ol2, la2, bz2, dn2;
  logic [1:0] k2, l2;
  logic [2:0] val2;
  loop_walk_seq #(.NumOuter(8), .ClogMode(1'b1)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(st2), .ready_i(rdy2), .valid_o(v2),
    .outer_idx_o(k2), .inner_idx_o(l2), .value_o(val2), .outer_last_o(ol2),
    .last_o(la2), .busy_o(bz2), .done_o(dn2));

  // ---------------- DUT3: NumOuter=5 -> OC=5 ----------------
  logic       st3 = 1'b0, rdy3 = 1'b1;
  logic       v3, ol3, la3, bz3, dn3;
  logic [2:0] k3;
  logic [3:0] l3;
  logic [4:0] val3;
  loop_walk_seq #(.NumOuter(5), .ClogMode(1'b0)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(st3), .ready_i(rdy3), .valid_o(v3),
    .outer_idx_o(k3), .inner_idx_o(l3), .value_o(val3), .outer_last_o(ol3),
    .last_o(la3), .busy_o(bz3), .done_o(dn3));

  // ---------------- DUT0 scoreboard ----------------
  typedef struct { int k; int l; int v; int ol; int la; } beat_t;
  beat_t q0[$];

  // hand-computed default walk
  localparam int TK [7] = '{0, 1, 1, 2, 2, 2, 2};
  localparam int TL [7] = '{0, 0, 1, 0, 1, 2, 3};
  localparam int TV [7] = '{1, 2, 3, 4, 5, 6, 7};
  localparam int TOL[7] = '{1, 0, 1, 0, 0, 0, 1};
  localparam int TLA[7] = '{0, 0, 0, 0, 0, 0, 1};

  task automatic push_walk0();
    beat_t b;
    for (int i = 0; i < 7; i++) begin
      b.k = TK[i]; b.l = TL[i]; b.v = TV[i]; b.ol = TOL[i]; b.la = TLA[i];
      q0.push_back(b);
    end
  endtask

  logic [8:0] snap0, prev0;
  logic       hold0 = 1'b0;
  int         last_hs_cyc = -10;
  assign snap0 = {k0, l0, val0, ol0, la0};

  task automatic mon0();
    beat_t e;
    if (hold0) chk("hold_stable", v0 ? int'(snap0) : -1, int'(prev0));
    if (v0 && rdy0) begin
      if (q0.size() == 0) chk("extra_beat", int'(val0), 0);
      else begin
        e = q0.pop_front();
        chk("beat_k", int'(k0), e.k);
        chk("beat_l", int'(l0), e.l);
        chk("beat_value", int'(val0), e.v);
        chk("beat_outer_last", int'(ol0), e.ol);
        chk("beat_last", int'(la0), e.la);
        if (la0) last_hs_cyc = cyc;
      end
    end
  endtask

  always @(negedge clk) begin
    mon0();
    hold0 <= v0 && !rdy0 && !rst;
    prev0 <= snap0;
  end

  // DUT1 must never present a beat
  always @(negedge clk) if (v1) chk("dut1_no_beats", int'(v1), 0);

  // ---------------- DUT2/DUT3 model monitors ----------------
  function automatic int exp_k(input int v);
    return $clog2(v + 1) - 1;
  endfunction

  int n2 = 0, lastv2 = 0, n3 = 0, lastv3 = 0;
  always @(negedge clk) begin
    if (v2 && rdy2) begin
      chk("d2_value", int'(val2), n2 + 1);
      chk("d2_k", int'(k2), exp_k(n2 + 1));
      chk("d2_l", int'(l2), n2 + 1 - (1 << exp_k(n2 + 1)));
      chk("d2_outer_last", int'(ol2), int'(((n2 + 2) & (n2 + 1)) == 0));
      chk("d2_last", int'(la2), int'(n2 + 1 == 7));
      n2     <= n2 + 1;
      lastv2 <= int'(val2);
    end
    if (v3 && rdy3) begin
      chk("d3_value", int'(val3), n3 + 1);
      chk("d3_k", int'(k3), exp_k(n3 + 1));
      chk("d3_l", int'(l3), n3 + 1 - (1 << exp_k(n3 + 1)));
      chk("d3_outer_last", int'(ol3), int'(((n3 + 2) & (n3 + 1)) == 0));
      chk("d3_last", int'(la3), int'(n3 + 1 == 31));
      n3     <= n3 + 1;
      lastv3 <= int'(val3);
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse0();
    @(posedge clk); #1 st0 = 1'b1;
    @(posedge clk); #1 st0 = 1'b0;
  endtask

  task automatic wait_done0(input bit bp);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (dn0) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        if (bp) rdy0 = 1'($urandom_range(0, 1));
      end
    end
    chk("done_seen", int'(seen), 1);
    if (seen) begin
      chk("busy_at_done", int'(bz0), 1);
      chk("done_after_last", cyc, last_hs_cyc + 1);
      chk("queue_drained", q0.size(), 0);
      @(negedge clk);
      chk("idle_after_done", int'({bz0, dn0, v0}), 0);
    end
    rdy0 = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int dc[2];
    int nd;
    bit found;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(v0), 0);
    chk("rst_outer_idx", int'(k0), 0);
    chk("rst_inner_idx", int'(l0), 0);
    chk("rst_value", int'(val0), 0);
    chk("rst_outer_last", int'(ol0), 0);
    chk("rst_last", int'(la0), 0);
    chk("rst_busy", int'(bz0), 0);
    chk("rst_done", int'(dn0), 0);
    chk("rst_d3_value", int'(val3), 0);
    @(posedge clk); #1 rst = 1'b0;

    // full-throughput default walk
    push_walk0();
    pulse0();
    @(negedge clk);
    chk("first_beat_valid", int'(v0), 1);
    chk("first_beat_value", int'(val0), 1);
    wait_done0(1'b0);

    // random back-pressure
    push_walk0();
    pulse0();
    wait_done0(1'b1);

    // start held high: restart only from IDLE, period = 9
    push_walk0();
    push_walk0();
    nd = 0;
    @(posedge clk); #1 st0 = 1'b1;
    for (int i = 0; i < 100 && nd < 2; i++) begin
      @(negedge clk);
      if (dn0) begin dc[nd] = cyc; nd++; end
    end
    @(posedge clk); #1 st0 = 1'b0;
    chk("held_start_dones", nd, 2);
    if (nd == 2) chk("held_start_period", dc[1] - dc[0], 9);
    repeat (3) @(negedge clk);
    chk("held_start_drained", q0.size(), 0);
    chk("held_start_idle", int'(v0), 0);

    // reset during the value-4 beat
    push_walk0();
    pulse0();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (v0 && val0 == 3'd4) found = 1'b1;
    end
    chk("rst_mid_found_value4", int'(found), 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_outputs", int'({v0, k0, l0, val0, ol0, la0}), 0);
    chk("rst_mid_busy_done", int'({bz0, dn0}), 0);
    q0.delete();
    @(posedge clk); #1 rst = 1'b0;
    push_walk0();
    pulse0();
    @(negedge clk);
    chk("post_rst_first_value", int'(val0), 1);
    wait_done0(1'b0);

    // degenerate walk: OC=0
    @(posedge clk); #1 st1 = 1'b1;
    @(posedge clk); #1 st1 = 1'b0;
    @(negedge clk);
    chk("degen_done", int'(dn1), 1);
    chk("degen_busy", int'(bz1), 1);
    chk("degen_valid", int'(v1), 0);
    @(negedge clk);
    chk("degen_done_gone", int'(dn1), 0);
    chk("degen_busy_gone", int'(bz1), 0);

    // OC=3 via clog mode and OC=5 walks in parallel
    @(posedge clk); #1 st2 = 1'b1; st3 = 1'b1;
    @(posedge clk); #1 st2 = 1'b0; st3 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (dn3) found = 1'b1;
    end
    chk("d3_done_seen", int'(found), 1);
    chk("d2_beats", n2, 7);
    chk("d2_last_value", lastv2, 7);
    chk("d3_beats", n3, 31);
    chk("d3_last_value", lastv3, 31);
    @(negedge clk);
    chk("d2_d3_idle", int'({bz2, bz3, dn2, dn3}), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/loop_walk_seq.md
# loop_walk_seq

Runtime sequencer for the nested generate-loop iteration space that the unroll test elaborates statically. On `start_i` it walks outer index k from 0 to OuterCount-1 and, for each k, inner index l from 0 to 2**k-1, emitting one beat per (k, l) with value 2**k+l over a valid/ready stream. Downstream consumers, such as per-iteration configuration writers, read the same index/value tuples at runtime that the unrolled elaboration produces.

## Interface
- `NumOuter`, default 3: base outer loop bound, at least 1.
- `ClogMode`, default 1'b0: 0 sets OuterCount = NumOuter; 1 sets OuterCount = $clog2(NumOuter).
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: start request; sampled only in IDLE.
- `ready_i` in 1: downstream ready.
- `valid_o` out 1: beat valid.
- `outer_idx_o` out OW: current k. OW = max(1, $clog2(OuterCount)).
- `inner_idx_o` out IW: current l. IW = max(1, OuterCount-1).
- `value_o` out VW: 2**k+l. VW = max(1, OuterCount).
- `outer_last_o` out 1: l == 2**k-1.
- `last_o` out 1: final beat of the walk.
- `busy_o` out 1: state is not IDLE.
- `done_o` out 1: one-cycle pulse after the walk completes.

## Operation
- States:
  - IDLE: `valid_o` = 0.
  - RUN: `valid_o` = 1.
  - DONE: `done_o` = 1 for exactly one cycle.
- IDLE with `start_i`=1:
  - OuterCount > 0: go to RUN with k=0, l=0.
  - OuterCount == 0: go directly to DONE; no beats are emitted.
- RUN, handshake (`valid_o` && `ready_i`):
  - not `outer_last_o`: l increments.
  - `outer_last_o` and not `last_o`: k increments and l resets to 0.
  - `last_o`: go to DONE.
- RUN without a handshake: all outputs hold stable. Stream rules are AXI-like: `valid_o` never drops while waiting; `ready_i` may toggle freely.
- DONE goes to IDLE unconditionally.
- `start_i` is ignored in RUN and DONE. It is not queued.
- Arithmetic:
  - `value_o` = (1 << k) | l, valid because l < 2**k. Over a full walk it is the contiguous sequence 1 .. 2**OuterCount-1.
  - `last_o` = (k == OuterCount-1) && `outer_last_o`.
  - Compare and shift widths are sized from package functions. No truncation is allowed at OuterCount up to 16.
- Total beats per walk = 2**OuterCount - 1.

## Timing
- Reset value of every output is 0, and state is IDLE. This holds for `valid_o`, `outer_idx_o`, `inner_idx_o`, `value_o`, `outer_last_o`, `last_o`, `busy_o` and `done_o`.
- `rst_i` asserted mid-walk: state returns to IDLE and all counters clear asynchronously. The walk is not resumed after deassertion.
- All outputs are registered or decoded only from state/counter registers. There is no combinational path from `ready_i` or `start_i` to any output.
- Latency:
  - `start_i` sampled at edge t: first beat valid after edge t, with k=0, l=0, value=1.
  - Each handshake at edge t presents the next beat after edge t, giving throughput of 1 beat/cycle with `ready_i` held high.
  - Handshake of the last beat at edge t: `done_o` = 1 and `busy_o` = 1 after edge t; IDLE after edge t+1.
  - Degenerate walk (OuterCount == 0): `done_o` is high in the cycle after the `start_i` edge.
- Minimum start-to-start period = beats + 2 cycles.

## Structure
- Package `loop_walk_pkg` holds the following:
  - state enum `loop_walk_state_e` (IDLE, RUN, DONE);
  - functions `outer_count(NumOuter, ClogMode)`, `outer_w`, `inner_w` and `value_w`.
- Single module. No sub-module is needed; the k and l counters live inline with the FSM.
- Counters advance only on a handshake or on start.

## Test plan
- Defaults (OuterCount=3), `start_i` pulse with `ready_i`=1 -> 7 consecutive beats:
  - (k,l,value) = (0,0,1), (1,0,2), (1,1,3), (2,0,4), (2,1,5), (2,2,6), (2,3,7);
  - `outer_last_o` on values 1, 3 and 7; `last_o` only on 7;
  - `done_o` pulse one cycle after beat 7.
- Random `ready_i` back-pressure -> identical value sequence; outputs stable while `valid_o` && !`ready_i`; no dropped or duplicated beats.
- `start_i` held high throughout -> walks restart only from IDLE; period = 9 cycles at full throughput.
- `ClogMode`=1, `NumOuter`=1 -> no beats; `done_o` pulses one cycle after start; `busy_o` high for one cycle.
- `rst_i` asserted during the beat with value 4 -> all outputs go to 0 immediately. The next start begins again at value 1.
- `ClogMode`=1, `NumOuter`=8 (OuterCount=3), and `NumOuter`=5 with `ClogMode`=0 -> beat counts of 7 and 31; last `value_o` = 7 and 31 respectively.
